mem_dump_uart: RTL and testbench

Memory-dump engine for board bring-up: on a debounced start pulse it walks a word-addressed synchronous memory from address 0 to `LAST_ADDR` and serialises every 32-bit word out of a UART TX pin (8N1). It sits beside the LED memory viewer on the same read port (`addr`/`en`/`din`) and consumes the same memory words. The viewer shows one byte at a time; this block streams the whole region to a host terminal.

---
 rtl/mem_dump_uart_if.sv | 12 +
 rtl/mem_dump_uart.sv | 182 ++++++++++++++++++
 tb/tb_mem_dump_uart.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_uart_if.sv
// Memory read port between the dump engine (master) and the word memory (slave).
// Read data is expected on din the cycle after en.
interface mem_dump_uart_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  en;
    logic [31:0]           din;

    modport master (output addr, output en, input din);
    modport slave  (input addr, input en, output din);
endinterface

// File: rtl/mem_dump_uart.sv
// Memory-dump engine: walks word addresses 0..LAST_ADDR and streams every word
// out of an 8N1 UART pin.
// Build option MEM_DUMP_HEX_EN: defined -> 8 uppercase hex digits + CR LF per word,
// undefined -> 4 raw bytes per word, little-endian.
//
// state | meaning
// IDLE  | waiting for i_start, line idle high
// READ  | one-cycle en pulse at r_addr
// WAIT  | absorbs memory read latency
// LOAD  | captures din, arms the character sequencer
// SEND  | serialises the characters of the word back-to-back
// NEXT  | finishes (done) or advances the address
module mem_dump_uart #(
    parameter int ADDR_WIDTH  = 8,
    parameter int LAST_ADDR   = 2**ADDR_WIDTH - 1,
    parameter int CLK_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    mem_dump_uart_if.master bus,
    output logic            o_txd,
    output logic            o_busy,
    output logic            o_done
);
`ifdef MEM_DUMP_HEX_EN
    localparam int LP_NCHAR = 10;
`else
    localparam int LP_NCHAR = 4;
`endif
    localparam int                    LP_CW        = $clog2(CLK_PER_BIT);
    localparam logic [LP_CW-1:0]      LP_BAUD_LAST = LP_CW'(CLK_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST      = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [3:0]            LP_CHAR_LAST = 4'(LP_NCHAR - 1);
    localparam logic [3:0]            LP_BIT_STOP  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_NEXT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
    logic [31:0]           r_word,     w_word_nxt;
    logic [3:0]            r_char_idx, w_char_nxt;
    logic [3:0]            r_bit_idx,  w_bit_nxt;
    logic [LP_CW-1:0]      r_baud,     w_baud_nxt;
    logic                  r_txd,      w_txd_nxt;
    logic                  w_en;
    logic                  w_done;
    logic [7:0]            w_char;

    // Character idx of a word as it appears on the wire.
    function automatic logic [7:0] f_char(input logic [31:0] word, input logic [3:0] idx);
        logic [7:0] c;
`ifdef MEM_DUMP_HEX_EN
        logic [3:0] nib;
        nib = word[(5'd28 - {idx[2:0], 2'b00}) +: 4];
        if (idx == 4'd8)
            c = 8'h0D;
        else if (idx == 4'd9)
            c = 8'h0A;
        else
            c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
        case (idx)
            4'd0:    c = word[7:0];
            4'd1:    c = word[15:8];
            4'd2:    c = word[23:16];
            default: c = word[31:24];
        endcase
`endif
        return c;
    endfunction

    // State and datapath registers; txd is registered so the pin never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_word     <= '0;
            r_char_idx <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_word     <= w_word_nxt;
            r_char_idx <= w_char_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_baud     <= w_baud_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // Next-state, address walk, bit timer and the value txd takes next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_word_nxt  = r_word;
        w_char_nxt  = r_char_idx;
        w_bit_nxt   = r_bit_idx;
        w_baud_nxt  = r_baud;
        w_txd_nxt   = 1'b1;
        w_en        = 1'b0;
        w_done      = 1'b0;
        w_char      = f_char(r_word, r_char_idx);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_READ;
                    w_addr_nxt  = '0;
                end
            end
            S_READ: begin
                w_en        = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_word_nxt  = bus.din;
                w_char_nxt  = '0;
                w_bit_nxt   = '0;
                w_baud_nxt  = LP_BAUD_LAST;
                w_txd_nxt   = 1'b0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_txd_nxt = r_txd;
                if (r_baud != '0) begin
                    w_baud_nxt = r_baud - 1'b1;
                end else begin
                    w_baud_nxt = LP_BAUD_LAST;
                    if (r_bit_idx != LP_BIT_STOP) begin
                        // bit_idx 0 is the start bit, so the next bit is data[bit_idx] or the stop bit
                        w_bit_nxt = r_bit_idx + 4'd1;
                        w_txd_nxt = (r_bit_idx == 4'd8) ? 1'b1 : w_char[r_bit_idx[2:0]];
                    end else begin
                        w_bit_nxt = '0;
                        if (i_abort) begin
                            w_state_nxt = S_IDLE;
                            w_addr_nxt  = '0;
                            w_txd_nxt   = 1'b1;
                        end else if (r_char_idx == LP_CHAR_LAST) begin
                            w_state_nxt = S_NEXT;
                            w_txd_nxt   = 1'b1;
                        end else begin
                            w_char_nxt = r_char_idx + 4'd1;
                            w_txd_nxt  = 1'b0;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (r_addr == LP_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.addr = r_addr;
    assign bus.en   = w_en;
    assign o_txd    = r_txd;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = w_done;
endmodule

// File: tb/tb_mem_dump_uart.sv
// Bench for mem_dump_uart: expected characters and read addresses are queued
// when a dump is started and consumed by the UART decoder / en monitor.
module tb_mem_dump_uart;
    localparam int AW   = 2;
    localparam int LAST = 3;
    localparam int CPB  = 4;
`ifdef MEM_DUMP_HEX_EN
    localparam int NCH = 10;
`else
    localparam int NCH = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic txd, busy, done;

    mem_dump_uart_if #(.ADDR_WIDTH(AW)) u_bus();

    mem_dump_uart #(.ADDR_WIDTH(AW), .LAST_ADDR(LAST), .CLK_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .i_abort (abort),
        .bus     (u_bus),
        .o_txd   (txd),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4];
    always @(posedge clk) if (u_bus.en) u_bus.din <= mem[u_bus.addr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    exp_q[$];
    logic [AW-1:0] en_q[$];
    int            en_cyc_q[$];
    int            rx_start_q[$];
    int            en_cnt = 0, done_cnt = 0, rx_cnt = 0, done_cyc = 0;
    logic          prev_done = 1'b0, busy_after_done = 1'b1;
    logic          rx_act = 1'b0;
    int            rx_n = 0;
    logic [39:0]   rx_smp;
    logic [7:0]    rx_b;
    logic          rx_ok;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [31:0] w, input int i);
`ifdef MEM_DUMP_HEX_EN
        logic [3:0] nib;
        if (i == 8) return 8'h0D;
        if (i == 9) return 8'h0A;
        nib = w[31-4*i -: 4];
        return (nib <= 4'd9) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10);
`else
        return w[8*i +: 8];
`endif
    endfunction

    task automatic push_words(input int nwords, input int nchars_last);
        for (int a = 0; a < nwords; a++) begin
            en_q.push_back(AW'(a));
            for (int i = 0; i < ((a == nwords - 1) ? nchars_last : NCH); i++)
                exp_q.push_back(exp_char(mem[a], i));
        end
    endtask

    task automatic clear_logs();
        en_cyc_q.delete();
        rx_start_q.delete();
        en_cnt = 0; done_cnt = 0; rx_cnt = 0;
    endtask

    task automatic pulse_start(output int t, input logic with_abort);
        @(posedge clk); #1;
        start = 1'b1;
        if (with_abort) abort = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < lim) begin @(negedge clk); n++; end
        chk(tag, (n < lim), 1);
    endtask

    // Monitors: en/addr, done, and a UART decoder sampling at negedges.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) busy_after_done = busy;
            prev_done = done;
            if (u_bus.en === 1'b1) begin
                en_cnt++;
                en_cyc_q.push_back(cyc);
                chk("en_pending", (en_q.size() > 0), 1);
                if (en_q.size() > 0) chk("en_addr", u_bus.addr, en_q.pop_front());
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!rx_act && txd === 1'b0) begin
                rx_act = 1'b1;
                rx_n   = 0;
                rx_start_q.push_back(cyc);
            end
            if (rx_act) begin
                rx_smp[rx_n] = txd;
                rx_n++;
                if (rx_n == 40) begin
                    rx_act = 1'b0;
                    rx_ok  = 1'b1;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < 4; j++)
                            if (rx_smp[4*k+j] !== rx_smp[4*k]) rx_ok = 1'b0;
                    for (int i = 0; i < 8; i++) rx_b[i] = rx_smp[4*(i+1)+2];
                    rx_cnt++;
                    chk("bit_width", rx_ok, 1);
                    chk("stop_bit", rx_smp[38], 1);
                    chk("rx_pending", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("rx_byte", rx_b, exp_q.pop_front());
                end
            end
        end
    end

    int t0, tdummy, n;

    initial begin
        mem[0] = 32'h12345678;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'h0000ABCF;
        mem[3] = 32'hA5C30F96;
        u_bus.din = '0;

        // reset values
        #12;
        chk("rst_addr", u_bus.addr, 0);
        chk("rst_en", u_bus.en, 0);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #10 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // full dump with ignored extra start pulses
        clear_logs();
        push_words(4, NCH);
        pulse_start(t0, 1'b0);
        repeat (50) @(posedge clk);
        chk("busy_running", busy, 1);
        pulse_start(tdummy, 1'b0);
        repeat (100) @(posedge clk);
        pulse_start(tdummy, 1'b0);
        wait_idle("dump_timeout", 5000);
        repeat (5) @(negedge clk);
        chk("dump_en_cnt", en_cnt, 4);
        chk("dump_done_cnt", done_cnt, 1);
        chk("dump_left", exp_q.size(), 0);
        chk("dump_rx_cnt", rx_cnt, 4 * NCH);
        chk("busy_after_done", busy_after_done, 0);
        chk("txd_idle", txd, 1);
        if (en_cyc_q.size() > 0) chk("en_latency", en_cyc_q[0], t0 + 1);
        if (rx_start_q.size() == 4 * NCH) begin
            chk("txd_latency", rx_start_q[0], t0 + 4);
            for (int k = 1; k < 4 * NCH; k++)
                chk("char_spacing", rx_start_q[k] - rx_start_q[k-1], (k % NCH == 0) ? 44 : 40);
            chk("done_cycle", done_cyc, rx_start_q[4*NCH-1] + 40);
        end

        // abort during second character of word 0
        clear_logs();
        push_words(1, 2);
        pulse_start(t0, 1'b0);
        n = 0;
        while (rx_cnt < 1 && n < 500) begin @(posedge clk); n++; end
        chk("abort_wait", (n < 500), 1);
        repeat (15) @(posedge clk);
        #1 abort = 1'b1;
        wait_idle("abort_timeout", 500);
        #1 abort = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_rx_cnt", rx_cnt, 2);
        chk("abort_done", done_cnt, 0);
        chk("abort_addr", u_bus.addr, 0);
        chk("abort_en_cnt", en_cnt, 1);
        chk("abort_left", exp_q.size(), 0);

        // restart after abort dumps from address 0
        clear_logs();
        push_words(4, NCH);
        pulse_start(t0, 1'b0);
        wait_idle("redump_timeout", 5000);
        repeat (3) @(negedge clk);
        chk("redump_done", done_cnt, 1);
        chk("redump_en_cnt", en_cnt, 4);
        chk("redump_left", exp_q.size(), 0);

        // start and abort together: exactly one character
        clear_logs();
        push_words(1, 1);
        pulse_start(t0, 1'b1);
        wait_idle("sa_timeout", 500);
        #1 abort = 1'b0;
        repeat (50) @(negedge clk);
        chk("sa_rx_cnt", rx_cnt, 1);
        chk("sa_done", done_cnt, 0);
        chk("sa_addr", u_bus.addr, 0);
        chk("sa_left", exp_q.size(), 0);

        // reset in the middle of a data bit
        clear_logs();
        push_words(4, NCH);
        pulse_start(t0, 1'b0);
        n = 0;
        while (!rx_act && n < 100) begin @(posedge clk); n++; end
        chk("rst_wait", (n < 100), 1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_en", u_bus.en, 0);
        chk("midrst_addr", u_bus.addr, 0);
        exp_q.delete();
        en_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        n = rx_cnt;
        repeat (30) @(negedge clk);
        chk("postrst_busy", busy, 0);
        chk("postrst_txd", txd, 1);
        chk("postrst_en_cnt", en_cnt, 1);
        chk("postrst_rx_cnt", rx_cnt, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
